// File: rtl/exp_sched_pkg.sv
// Shared types and constants for the exponent-core issue scheduler.
// Imported by exp_tag_pipe and exp_issue_sched.
package exp_sched_pkg;

    typedef logic tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int CORE_LAT_DEF = 16;

    localparam tag_t REQ0 = 1'b0;
    localparam tag_t REQ1 = 1'b1;

endpackage

// File: rtl/exp_tag_pipe.sv
// Shift register of {valid, tag} that shadows the core pipeline so each
// result can be routed back to the requester that issued it.
module exp_tag_pipe
    import exp_sched_pkg::*;
#(
    parameter int DEPTH = CORE_LAT_DEF + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  tag_t in_tag,
    output logic out_valid,
    output tag_t out_tag
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] tags;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= '0;
            tags <= '0;
        end else begin
            vld  <= {vld[DEPTH-2:0], in_valid};
            tags <= {tags[DEPTH-2:0], in_tag};
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tags[DEPTH-1];

endmodule

// File: rtl/exp_issue_sched.sv
// Two-requester issue scheduler in front of the pipelined HHV2 exponent core.
// Define EXP_ISSUE_SCHED_RR_EN for round-robin; otherwise req0 has fixed priority.
module exp_issue_sched
    import exp_sched_pkg::*;
#(
    parameter int CORE_LAT = CORE_LAT_DEF,
    parameter int W        = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    input  logic [W-1:0]                  req0_data,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [W-1:0]                  req1_data,
    output logic                          req1_ready,
    input  logic                          pause,
    output logic [W-1:0]                  core_man,
    input  logic [W-1:0]                  core_xvo,
    input  logic [W-1:0]                  core_yvo,
    input  logic [W-1:0]                  core_zvo,
    output logic                          rsp0_valid,
    output logic                          rsp1_valid,
    output logic [W-1:0]                  rsp_x,
    output logic [W-1:0]                  rsp_y,
    output logic [W-1:0]                  rsp_z,
    output logic                          busy,
    output logic [$clog2(CORE_LAT+3)-1:0] inflight
);

    localparam int IW = $clog2(CORE_LAT + 3);

    state_t        state;
    state_t        state_nxt;
    logic          grant0;
    logic          grant1;
    logic          fire;
    tag_t          fire_tag;
    logic          ret_valid;
    tag_t          ret_tag;
    logic          retire;
    logic [IW-1:0] inflight_nxt;

`ifdef EXP_ISSUE_SCHED_RR_EN
    tag_t ptr;

    // On contention, the requester not granted last time wins.
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid;
        if (req0_valid && req1_valid) begin
            grant0 = (ptr == REQ1);
            grant1 = (ptr == REQ0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ1;
        end else if (fire) begin
            ptr <= fire_tag;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    assign req0_ready = grant0 && !pause && !rst;
    assign req1_ready = grant1 && !pause && !rst;
    assign fire       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign fire_tag   = req1_ready ? REQ1 : REQ0;
    assign retire     = rsp0_valid || rsp1_valid;
    assign busy       = (inflight != '0) || fire;

    exp_tag_pipe #(
        .DEPTH(CORE_LAT + 1)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (fire),
        .in_tag   (fire_tag),
        .out_valid(ret_valid),
        .out_tag  (ret_tag)
    );

    always_comb begin
        inflight_nxt = inflight;
        unique case (1'b1)
            fire && !retire: inflight_nxt = inflight + IW'(1);
            retire && !fire: inflight_nxt = inflight - IW'(1);
            default:         inflight_nxt = inflight;
        endcase
    end

    // Use the next count so IDLE coincides with inflight reading zero.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (fire) state_nxt = RUN;
            end
            RUN: begin
                if (inflight_nxt == '0 && !fire) state_nxt = IDLE;
                else if (pause)                  state_nxt = DRAIN;
            end
            DRAIN: begin
                if (inflight_nxt == '0) state_nxt = IDLE;
                else if (!pause)        state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            core_man   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_x      <= '0;
            rsp_y      <= '0;
            rsp_z      <= '0;
            inflight   <= '0;
        end else begin
            state      <= state_nxt;
            inflight   <= inflight_nxt;
            rsp0_valid <= ret_valid && (ret_tag == REQ0);
            rsp1_valid <= ret_valid && (ret_tag == REQ1);
            if (fire) begin
                core_man <= req1_ready ? req1_data : req0_data;
            end
            if (ret_valid) begin
                rsp_x <= core_xvo;
                rsp_y <= core_yvo;
                rsp_z <= core_zvo;
            end
        end
    end

endmodule

// File: tb/tb_exp_issue_sched.sv
// Directed bench for exp_issue_sched with a behavioural 16-stage core model.
// Expectations follow EXP_ISSUE_SCHED_RR_EN when the design is built with it.
module tb_exp_issue_sched;
    import exp_sched_pkg::*;

    localparam int LAT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        pause;
    logic [31:0] core_man;
    logic [31:0] core_xvo;
    logic [31:0] core_yvo;
    logic [31:0] core_zvo;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_x;
    logic [31:0] rsp_y;
    logic [31:0] rsp_z;
    logic        busy;
    logic [4:0]  inflight;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] pipe [LAT];

    always #5 clk = ~clk;

    exp_issue_sched #(.CORE_LAT(LAT), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .pause     (pause),
        .core_man  (core_man),
        .core_xvo  (core_xvo),
        .core_yvo  (core_yvo),
        .core_zvo  (core_zvo),
        .rsp0_valid(rsp0_valid),
        .rsp1_valid(rsp1_valid),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rsp_z     (rsp_z),
        .busy      (busy),
        .inflight  (inflight)
    );

    // Core stand-in: fixed latency, distinct function per output.
    always @(posedge clk) begin
        pipe[0] <= core_man;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_xvo = pipe[LAT-1] ^ 32'hFFFF0000;
    assign core_yvo = pipe[LAT-1] + 32'h1;
    assign core_zvo = {pipe[LAT-1][15:0], pipe[LAT-1][31:16]};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (rsp0_valid || rsp1_valid) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int          n;
    logic [3:0]  exp_g;
    logic [31:0] xa;
    logic [31:0] xb;

    initial begin
        rst = 1'b1;
        pause = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data = 32'h0;
        req1_data = 32'h0;
        tick();
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("rst_core_man", core_man, 32'h0);
        chk("rst_rsp", {29'd0, rsp0_valid, rsp1_valid, busy}, 32'd0);
        chk("rst_rsp_x", rsp_x, 32'h0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        // Single op on req0.
        req0_valid = 1'b1;
        req0_data = 32'h01D4B2BE;
        #1;
        chk("single_ready0", 32'(req0_ready), 32'd1);
        chk("single_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("single_core_man", core_man, 32'h01D4B2BE);
        chk("single_inflight1", 32'(inflight), 32'd1);
        chk("single_busy1", 32'(busy), 32'd1);
        chk("single_state_run", 32'(dut.state), 32'(RUN));
        wait_rsp(30, n);
        chk("single_latency", n + 1, 32'd18);
        chk("single_rsp0", 32'(rsp0_valid), 32'd1);
        chk("single_rsp1", 32'(rsp1_valid), 32'd0);
        chk("single_x", rsp_x, 32'hFE2BB2BE);
        chk("single_y", rsp_y, 32'h01D4B2BF);
        chk("single_z", rsp_z, 32'hB2BE01D4);
        tick();
        chk("single_strobe", 32'(rsp0_valid), 32'd0);
        chk("single_inflight0", 32'(inflight), 32'd0);
        chk("single_busy0", 32'(busy), 32'd0);
        chk("single_state_idle", 32'(dut.state), 32'(IDLE));

        // Contention straight after reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef EXP_ISSUE_SCHED_RR_EN
        exp_g = 4'b1010;
`else
        exp_g = 4'b0000;
`endif
        xa = 32'hBF15495F;
        xb = 32'hBFB2967C;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data = 32'h40EA495F;
        req1_data = 32'h404D967C;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("cont_ready0_%0d", k), 32'(req0_ready), 32'(!exp_g[k]));
            chk($sformatf("cont_ready1_%0d", k), 32'(req1_ready), 32'(exp_g[k]));
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(30, n);
        chk("cont_first_rsp", n, 32'd14);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            chk($sformatf("cont_rsp0_%0d", k), 32'(rsp0_valid), 32'(!exp_g[k]));
            chk($sformatf("cont_rsp1_%0d", k), 32'(rsp1_valid), 32'(exp_g[k]));
            chk($sformatf("cont_x_%0d", k), rsp_x, exp_g[k] ? xb : xa);
        end
        tick();
        chk("cont_after", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);

        // Pause with five ops in flight.
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1;
            req0_data = 32'h100 + i;
            tick();
        end
        pause = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("pause_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        tick();
        chk("pause_state_drain", 32'(dut.state), 32'(DRAIN));
        chk("pause_inflight5", 32'(inflight), 32'd5);
        wait_rsp(30, n);
        chk("pause_first_rsp", n, 32'd12);
        for (int j = 1; j < 5; j++) begin
            tick();
            chk($sformatf("pause_rsp_%0d", j), 32'(rsp0_valid), 32'd1);
        end
        chk("pause_last_y", rsp_y, 32'h105);
        tick();
        chk("pause_done_rsp", 32'(rsp0_valid), 32'd0);
        chk("pause_inflight0", 32'(inflight), 32'd0);
        chk("pause_busy0", 32'(busy), 32'd0);
        chk("pause_state_idle", 32'(dut.state), 32'(IDLE));
        pause = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset while three ops are in flight.
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1;
            req0_data = 32'h200 + i;
            tick();
        end
        req0_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("midrst_ready0", 32'(req0_ready), 32'd0);
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;
        chk("midrst_inflight", 32'(inflight), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp0_valid || rsp1_valid) n++;
        end
        chk("midrst_no_rsp", n, 32'd0);
        req0_valid = 1'b1;
        req0_data = 32'h300;
        tick();
        req0_valid = 1'b0;
        wait_rsp(30, n);
        chk("midrst_next_latency", n + 1, 32'd18);
        chk("midrst_next_x", rsp_x, 32'hFFFF0300);
        tick();

        // Stream req1 alone: inflight saturates, one response per cycle.
        for (int k = 0; k < 40; k++) begin
            req1_valid = 1'b1;
            req1_data = 32'h10000000 + k;
            #1;
            chk($sformatf("stream_ready1_%0d", k), 32'(req1_ready), 32'd1);
            chk($sformatf("stream_ready0_%0d", k), 32'(req0_ready), 32'd0);
            chk($sformatf("stream_inflight_%0d", k), 32'(inflight),
                (k < 18) ? k : 18);
            chk($sformatf("stream_rsp1_%0d", k), 32'(rsp1_valid),
                32'(k >= 18));
            if (k == 0) chk("stream_busy", 32'(busy), 32'd1);
            if (k >= 18)
                chk($sformatf("stream_x_%0d", k), rsp_x,
                    (32'h10000000 + k - 18) ^ 32'hFFFF0000);
            tick();
        end
        req1_valid = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        chk("stream_drain_inflight", 32'(inflight), 32'd0);
        chk("stream_drain_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
